// File: rtl/rf_pkg.sv
// Shared types and sizes for the integer register-file write-back path.
package rf_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;
  localparam int NUM_REGS      = 32;

  // One queued register-file write.
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0]    data;
  } wb_entry_t;

  // Identifies which requester owns the write port; used as the last-grant pointer.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending register writes for one requester.
// Besides the head entry it exposes the destination of every occupied slot
// (empty slots read as register 0) so the top level can build a hazard mask.
module wb_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [ADDRESS_WIDTH-1:0]       push_dest,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic                           full,
  output logic                           empty,
  output logic [ADDRESS_WIDTH-1:0]       head_dest,
  output logic [DATA_WIDTH-1:0]          head_data,
  output logic [DEPTH*ADDRESS_WIDTH-1:0] dest_vec
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDRESS_WIDTH-1:0] dest_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
  logic [DEPTH-1:0]         slot_valid;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     do_push;
  logic                     do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_dest = dest_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Entry storage: written on push only.
  // NOTE: the storage array is deliberately not reset; slot_valid and count
  // decide what is live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      dest_mem[wr_ptr] <= push_dest;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointer, count and occupancy bookkeeping; pointers wrap modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else begin
      if (do_push) begin
        wr_ptr             <= wr_ptr + 1'b1;
        slot_valid[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr             <= rd_ptr + 1'b1;
        slot_valid[rd_ptr] <= 1'b0;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Destinations of occupied slots; free slots report register 0.
  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dest_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) dest_vec[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = dest_mem[i];
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: shares the register file's single write port between
// the ALU and the load unit, each buffered in its own FIFO, and publishes a
// pending-write mask for read-after-write stall detection in decode.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH    = rf_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
  parameter int NUM_REGS      = rf_pkg::NUM_REGS,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDRESS_WIDTH-1:0] alu_dest,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_WIDTH-1:0] mem_dest,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data,
  output logic [NUM_REGS-1:0]      pend_mask,
  output logic                     busy
);

  logic                                alu_full, alu_empty, mem_full, mem_empty;
  logic                                alu_push, mem_push, alu_pop, mem_pop;
  logic [ADDRESS_WIDTH-1:0]            alu_head_dest, mem_head_dest;
  logic [DATA_WIDTH-1:0]               alu_head_data, mem_head_data;
  logic [FIFO_DEPTH*ADDRESS_WIDTH-1:0] alu_dests, mem_dests;
  wb_src_e                             last_grant;

  // Ready reflects only the registered fill level; writes to x0 are
  // accepted and then silently dropped.
  assign alu_ready = !rst && !alu_full;
  assign mem_ready = !rst && !mem_full;
  assign alu_push  = alu_valid && alu_ready && (alu_dest != '0);
  assign mem_push  = mem_valid && mem_ready && (mem_dest != '0);

  wb_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (alu_push),
    .push_dest (alu_dest),
    .push_data (alu_data),
    .pop       (alu_pop),
    .full      (alu_full),
    .empty     (alu_empty),
    .head_dest (alu_head_dest),
    .head_data (alu_head_data),
    .dest_vec  (alu_dests)
  );

  wb_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_push),
    .push_dest (mem_dest),
    .push_data (mem_data),
    .pop       (mem_pop),
    .full      (mem_full),
    .empty     (mem_empty),
    .head_dest (mem_head_dest),
    .head_data (mem_head_data),
    .dest_vec  (mem_dests)
  );

  // Round-robin grant: a lone requester always wins; on a tie the one not
  // granted last time wins.
  always_comb begin
    alu_pop = !alu_empty && (mem_empty || (last_grant == WB_SRC_MEM));
    mem_pop = !mem_empty && !alu_pop;
  end

  // Write-port registers and last-grant pointer; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= WB_SRC_MEM;
      rg_wrt_en   <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
    end else begin
      rg_wrt_en <= alu_pop || mem_pop;
      if (alu_pop) begin
        last_grant  <= WB_SRC_ALU;
        rg_wrt_dest <= alu_head_dest;
        rg_wrt_data <= alu_head_data;
      end else if (mem_pop) begin
        last_grant  <= WB_SRC_MEM;
        rg_wrt_dest <= mem_head_dest;
        rg_wrt_data <= mem_head_data;
      end
    end
  end

  // Pending-write mask over both FIFOs plus the write being committed now.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pend_mask[alu_dests[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b1;
      pend_mask[mem_dests[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b1;
    end
    if (rg_wrt_en) pend_mask[rg_wrt_dest] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  assign busy = !alu_empty || !mem_empty || rg_wrt_en;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the integer register file. It is the only block that drives the register file's single synchronous write port (`rg_wrt_en`, `rg_wrt_dest`, `rg_wrt_data`). It shares that port between two write-back requesters, the ALU and the load/memory unit, and buffers each one in a small FIFO. It also exports a pending-write mask so the decode stage can stall on read-after-write hazards.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register width
- `ADDRESS_WIDTH`, 5: register address width
- `NUM_REGS`, 32: number of architectural registers
- `FIFO_DEPTH`, 2: entries per requester FIFO (power of two, ≥2)

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `alu_valid`  in  1  ALU write-back request
- `alu_ready`  out  1  ALU FIFO can accept
- `alu_dest`  in  ADDRESS_WIDTH  ALU destination register
- `alu_data`  in  DATA_WIDTH  ALU result
- `mem_valid`  in  1  load write-back request
- `mem_ready`  out  1  load FIFO can accept
- `mem_dest`  in  ADDRESS_WIDTH  load destination register
- `mem_data`  in  DATA_WIDTH  load result
- `rg_wrt_en`  out  1  register-file write enable (registered)
- `rg_wrt_dest`  out  ADDRESS_WIDTH  write address (registered)
- `rg_wrt_data`  out  DATA_WIDTH  write data (registered)
- `pend_mask`  out  NUM_REGS  bit r is set while any queued or in-flight write targets register r
- `busy`  out  1  any FIFO non-empty or `rg_wrt_en` high

## Operation
- **Handshake:** a transfer occurs when `x_valid && x_ready` at a rising edge. `x_ready = !full`.
  - `ready` does not depend on a same-cycle dequeue. There is no bypass.
  - `valid` may drop without a transfer; no stickiness is required.
- **x0 filtering:** a transfer with `dest == 0` is accepted but not enqueued. It never reaches the write port.
- **Ordering:** each FIFO preserves its own order.
  - Ordering between requesters is not guaranteed.
  - The issue stage must not issue a second writer to a register whose `pend_mask` bit is set.
- **Arbitration:** at most one grant per cycle, to one FIFO head.
  - If only one FIFO is non-empty, that FIFO is granted.
  - If both are non-empty, grant is round-robin: the requester not granted last time wins.
  - The last-grant pointer resets to MEM, so ALU wins the first tie after reset.
- **Grant action:** the granted FIFO pops. On that edge the output registers load `en=1` and the head's `dest`/`data`.
- **No grant:** `rg_wrt_en` loads 0. `rg_wrt_dest` and `rg_wrt_data` hold their previous values.
- **`pend_mask`:** combinational OR of one-hot(`dest`) over all valid entries in both FIFOs, plus `rg_wrt_dest` when `rg_wrt_en` is high. Bit 0 is always 0.
- **Reset:** on an edge with `rst=1`:
  - both FIFOs are flushed (pointers and counts 0) and the last-grant pointer is set to MEM;
  - `rg_wrt_en`, `rg_wrt_dest` and `rg_wrt_data` load 0;
  - reset mid-operation discards all queued writes.
- **During reset:** `alu_ready` and `mem_ready` are held 0 while `rst=1`.
- **After reset:** `pend_mask=0` and `busy=0`.

## Timing
- **Latency:**
  - Handshake at edge N.
  - The entry is a FIFO head during cycle N..N+1.
  - If granted during that cycle, `rg_wrt_en` is high during cycle N+1..N+2.
  - The register file commits at the falling edge inside that cycle.
  - Minimum is 1 cycle from accept edge to write-enable high.
- **Throughput:** one register-file write per cycle in aggregate. With both FIFOs busy, each requester gets one write per two cycles.
- **Full FIFO:** with `FIFO_DEPTH` entries, `ready=0` for the next cycle even if the head pops on the same edge. `ready` returns 1 the cycle after the pop.
- **Simultaneous events:** a push and a pop on the same FIFO at the same edge are legal when not full. The count is unchanged and ordering is preserved.
- **Pointer wrap:** FIFO pointers wrap modulo `FIFO_DEPTH`. A `log2(FIFO_DEPTH)+1`-bit count distinguishes full from empty.

## Structure
- **Package `rf_pkg`:**
  - `DATA_WIDTH`, `ADDRESS_WIDTH` and `NUM_REGS` constants;
  - the `wb_entry_t` struct {dest, data};
  - the `wb_src_e` enum {WB_SRC_ALU, WB_SRC_MEM} used by the last-grant pointer.
- **Sub-module `wb_fifo`:** parameterised synchronous FIFO with push/pop, full/empty, head output, and a flat `dest` vector of valid entries for mask generation. It is instantiated twice.
- **Top level:** the arbiter, output registers and mask logic live in `rf_wb_arbiter`.

## Test plan
- **Reset and single write:** reset, then ALU pushes dest=5, data=0xDEADBEEF. Required:
  - `rg_wrt_en` high exactly one cycle, with dest 5 and data 0xDEADBEEF;
  - `pend_mask[5]` set from the accept edge until `rg_wrt_en` falls.
- **x0 drop:** MEM pushes dest=0, data=0x1234. Required: accepted (`ready`=1), `rg_wrt_en` stays 0, `pend_mask`=0, `busy`=0.
- **Contention round-robin:** both push every cycle for 4 cycles (ALU dests 1–4, MEM dests 11–14). Required:
  - write order 1, 11, 2, 12, …;
  - each FIFO stays in order;
  - `ready` drops when a FIFO holds 2 entries.
- **Backpressure full:** MEM pushes 3 entries back-to-back while ALU is also queued. Required:
  - the third push is stalled by `mem_ready=0`;
  - no entry is lost or duplicated across 20 random cycles, checked by a scoreboard.
- **Reset mid-operation:** both FIFOs full, then `rst=1` for 1 cycle. Required:
  - the next cycle has `rg_wrt_en`=0, `pend_mask`=0 and `busy`=0;
  - queued writes never appear;
  - `ready`=0 during reset;
  - the first tie after reset grants ALU.
